pool_window_buf: RTL

Parametrised pooling line buffer for the CNN datapath. It max-pools groups of `POOL` consecutive input samples per channel into an on-chip map of `MAP_W`×`MAP_H` pooled values. As soon as each `K`×`K` window is complete in the map, it replays that window row-major to the next layer. It sits between a convolution stage and the following convolution/FC stage, with generic channel count, width, map size, kernel size and activation mode.

---
 rtl/pool_window_buf.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pool_window_buf.sv
// pool_window_buf: per-channel max-pool into an on-chip map, then
// replays every KxK window row-major once all its elements are stored.
module pool_window_buf #(
    parameter int DW    = 18,
    parameter int CH    = 2,
    parameter int POOL  = 4,
    parameter int MAP_W = 13,
    parameter int MAP_H = 13,
    parameter int K     = 3,
    parameter int RELU  = 1,
    localparam int AW   = $clog2(MAP_W*MAP_H+1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           strt,
    input  logic [CH*DW-1:0] din,
    input  logic           tx_done,
    input  logic           bsy_in,
    output logic           rdy,
    output logic [CH*DW-1:0] dout,
    output logic           dout_vld,
    output logic           win_first,
    output logic           win_last,
    output logic           frame_done,
    output logic           err_ovf
);

    localparam int NPIX = MAP_W * MAP_H;
    localparam int SW   = $clog2(POOL);
    localparam int KW   = $clog2(K + 1);
    localparam int RW   = $clog2(MAP_H + 1);
    localparam int CW   = $clog2(MAP_W + 1);

    localparam logic signed [DW-1:0] SEED =
        (RELU != 0) ? '0 : {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [0:0] {
        W_IDLE,
        W_ACC
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RD,
        R_STEP,
        R_DONE
    } r_state_t;

    w_state_t             w_st;
    logic [SW-1:0]        s_cnt;
    logic [AW-1:0]        wr_cnt;
    logic signed [DW-1:0] acc  [CH];
    logic signed [DW-1:0] smp  [CH];
    logic signed [DW-1:0] base [CH];
    logic signed [DW-1:0] mx   [CH];
    logic                 last_smp;
    logic                 full;
    logic                 we;

    r_state_t             r_st;
    logic [RW-1:0]        org_r;
    logic [CW-1:0]        org_c;
    logic [KW-1:0]        ei;
    logic [KW-1:0]        ej;
    logic [AW-1:0]        rd_addr;
    logic [AW-1:0]        win_end;
    logic                 el_first;
    logic                 el_last;
    logic                 win_final;
    logic                 re;

    // Running max; the first sample of a group compares against the seed.
    always_comb begin
        smp  = '{default: '0};
        base = '{default: '0};
        mx   = '{default: '0};
        for (int g = 0; g < CH; g++) begin
            smp[g]  = $signed(din[g*DW +: DW]);
            base[g] = (w_st == W_IDLE) ? SEED : acc[g];
            mx[g]   = (smp[g] > base[g]) ? smp[g] : base[g];
        end
    end

    assign last_smp = (w_st == W_ACC) && (s_cnt == SW'(POOL - 1));
    assign full     = (wr_cnt == AW'(NPIX));
    assign we       = last_smp && !full && !tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_st    <= W_IDLE;
            s_cnt   <= '0;
            wr_cnt  <= '0;
            err_ovf <= 1'b0;
            acc     <= '{default: '0};
        end else if (tx_done) begin
            w_st    <= W_IDLE;
            s_cnt   <= '0;
            wr_cnt  <= '0;
            err_ovf <= 1'b0;
            acc     <= '{default: '0};
        end else begin
            unique case (w_st)
                W_IDLE: begin
                    if (strt) begin
                        acc   <= mx;
                        s_cnt <= SW'(1);
                        w_st  <= W_ACC;
                    end
                end
                W_ACC: begin
                    if (last_smp) begin
                        if (full) begin
                            err_ovf <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                        w_st <= W_IDLE;
                    end else begin
                        acc   <= mx;
                        s_cnt <= s_cnt + SW'(1);
                    end
                end
                default: w_st <= W_IDLE;
            endcase
        end
    end

    assign win_end = AW'((int'(org_r) + K - 1) * MAP_W
                         + int'(org_c) + K - 1);
    assign rd_addr = AW'((int'(org_r) + int'(ei)) * MAP_W
                         + int'(org_c) + int'(ej));

    // Window ready once its bottom-right element has been written.
    assign rdy = (r_st != R_DONE) && (wr_cnt > win_end);

    assign el_first  = (ei == '0) && (ej == '0);
    assign el_last   = (ei == KW'(K - 1)) && (ej == KW'(K - 1));
    assign win_final = (org_r == RW'(MAP_H - K))
                    && (org_c == CW'(MAP_W - K));
    assign re        = (r_st == R_RD) && !tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= R_IDLE;
            org_r      <= '0;
            org_c      <= '0;
            ei         <= '0;
            ej         <= '0;
            dout_vld   <= 1'b0;
            win_first  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_vld   <= re;
            win_first  <= re && el_first;
            win_last   <= re && el_last;
            frame_done <= re && el_last && win_final;
            if (tx_done) begin
                r_st  <= R_IDLE;
                org_r <= '0;
                org_c <= '0;
                ei    <= '0;
                ej    <= '0;
            end else begin
                unique case (r_st)
                    R_IDLE: begin
                        if (rdy && !bsy_in) begin
                            r_st <= R_RD;
                            ei   <= '0;
                            ej   <= '0;
                        end
                    end
                    R_RD: begin
                        if (ej == KW'(K - 1)) begin
                            ej <= '0;
                            if (ei == KW'(K - 1)) begin
                                r_st <= R_STEP;
                            end else begin
                                ei <= ei + KW'(1);
                            end
                        end else begin
                            ej <= ej + KW'(1);
                        end
                    end
                    R_STEP: begin
                        if (win_final) begin
                            r_st <= R_DONE;
                        end else begin
                            if (org_c == CW'(MAP_W - K)) begin
                                org_c <= '0;
                                org_r <= org_r + RW'(1);
                            end else begin
                                org_c <= org_c + CW'(1);
                            end
                            r_st <= R_IDLE;
                        end
                    end
                    R_DONE: begin
                        r_st <= R_DONE;
                    end
                    default: r_st <= R_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ram
        logic [DW-1:0] mem [NPIX];
        logic [DW-1:0] q;

        always_ff @(posedge clk) begin
            if (we) begin
                mem[wr_cnt] <= mx[g];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (re) begin
                q <= mem[rd_addr];
            end
        end

        assign dout[g*DW +: DW] = q;
    end

endmodule
